// File: rtl/exec_arbiter_if.sv
// exec_arbiter_if: requester, response and execution-unit signals
// shared between the arbiter (slave) and its environment (master).
interface exec_arbiter_if;
    logic        req0_valid;
    logic        req1_valid;
    logic        req0_ready;
    logic        req1_ready;
    logic [63:0] req0_a;
    logic [63:0] req0_b;
    logic [63:0] req1_a;
    logic [63:0] req1_b;
    logic [7:0]  req0_op;
    logic [7:0]  req1_op;
    logic        rsp0_valid;
    logic        rsp1_valid;
    logic        rsp0_ready;
    logic        rsp1_ready;
    logic [63:0] rsp_y;
    logic [4:0]  rsp_flags;
    logic        busy;
    logic [63:0] eu_a;
    logic [63:0] eu_b;
    logic [1:0]  eu_shift_fn;
    logic [1:0]  eu_logic_fn;
    logic [1:0]  eu_func_class;
    logic        eu_add_n_sub;
    logic        eu_ext_word;
    logic [63:0] eu_y;
    logic        eu_zero;
    logic        eu_alt_b;
    logic        eu_alt_bu;
    logic        eu_cout;
    logic        eu_ovfl;

    modport slave (
        input  req0_valid, req1_valid,
        input  req0_a, req0_b, req1_a, req1_b,
        input  req0_op, req1_op,
        input  rsp0_ready, rsp1_ready,
        input  eu_y, eu_zero, eu_alt_b, eu_alt_bu, eu_cout, eu_ovfl,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid,
        output rsp_y, rsp_flags, busy,
        output eu_a, eu_b, eu_shift_fn, eu_logic_fn, eu_func_class,
        output eu_add_n_sub, eu_ext_word
    );

    modport master (
        output req0_valid, req1_valid,
        output req0_a, req0_b, req1_a, req1_b,
        output req0_op, req1_op,
        output rsp0_ready, rsp1_ready,
        output eu_y, eu_zero, eu_alt_b, eu_alt_bu, eu_cout, eu_ovfl,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid,
        input  rsp_y, rsp_flags, busy,
        input  eu_a, eu_b, eu_shift_fn, eu_logic_fn, eu_func_class,
        input  eu_add_n_sub, eu_ext_word
    );
endinterface

// File: rtl/exec_arbiter.sv
// exec_arbiter: round-robin arbiter and sequencer feeding two
// requesters into one shared 64-bit execution unit.
module exec_arbiter #(
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic          clk,
    input  logic          reset_n,
    exec_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_prio;
    logic        r_owner;
    logic [63:0] r_eu_a;
    logic [63:0] r_eu_b;
    logic [7:0]  r_eu_op;
    logic [63:0] r_rsp_y;
    logic [4:0]  r_rsp_flags;

    logic        w_any;
    logic        w_grant;
    logic        w_accept;
    logic        w_rsp_take;
    logic [63:0] w_sel_a;
    logic [63:0] w_sel_b;
    logic [7:0]  w_sel_op;

    assign w_any = bus.req0_valid | bus.req1_valid;

    // A lone requester wins regardless of the priority pointer.
    always_comb begin
        w_grant = r_prio;
        unique case (1'b1)
            bus.req0_valid & ~bus.req1_valid: w_grant = 1'b0;
            ~bus.req0_valid & bus.req1_valid: w_grant = 1'b1;
            default:                          w_grant = r_prio;
        endcase
    end

    assign w_accept   = (r_state == ST_IDLE) & w_any;
    assign w_rsp_take = (r_state == ST_HOLD) &
                        (r_owner ? bus.rsp1_ready : bus.rsp0_ready);

    assign w_sel_a  = w_grant ? bus.req1_a  : bus.req0_a;
    assign w_sel_b  = w_grant ? bus.req1_b  : bus.req0_b;
    assign w_sel_op = w_grant ? bus.req1_op : bus.req0_op;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_EXEC;
            ST_EXEC: w_next = ST_HOLD;
            ST_HOLD: if (w_rsp_take) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp0_valid = 1'b0;
        bus.rsp1_valid = 1'b0;
        bus.busy       = (r_state != ST_IDLE);
        if (w_accept) begin
            bus.req0_ready = ~w_grant;
            bus.req1_ready = w_grant;
        end
        if (r_state == ST_HOLD) begin
            bus.rsp0_valid = ~r_owner;
            bus.rsp1_valid = r_owner;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prio      <= PRIO_INIT;
            r_owner     <= 1'b0;
            r_eu_a      <= '0;
            r_eu_b      <= '0;
            r_eu_op     <= '0;
            r_rsp_y     <= '0;
            r_rsp_flags <= '0;
        end else begin
            if (w_accept) begin
                r_owner <= w_grant;
                r_eu_a  <= w_sel_a;
                r_eu_b  <= w_sel_b;
                r_eu_op <= w_sel_op;
            end
            if (r_state == ST_EXEC) begin
                r_rsp_y     <= bus.eu_y;
                r_rsp_flags <= {bus.eu_zero, bus.eu_alt_b, bus.eu_alt_bu,
                                bus.eu_cout, bus.eu_ovfl};
            end
            if (w_rsp_take) begin
                r_prio <= ~r_owner;
            end
        end
    end

    assign bus.eu_a          = r_eu_a;
    assign bus.eu_b          = r_eu_b;
    assign bus.eu_shift_fn   = r_eu_op[1:0];
    assign bus.eu_logic_fn   = r_eu_op[3:2];
    assign bus.eu_func_class = r_eu_op[5:4];
    assign bus.eu_add_n_sub  = r_eu_op[6];
    assign bus.eu_ext_word   = r_eu_op[7];
    assign bus.rsp_y         = r_rsp_y;
    assign bus.rsp_flags     = r_rsp_flags;
endmodule

// File: tb/tb_exec_arbiter.sv
// tb_exec_arbiter: directed and random stimulus against a
// transaction-level model of the arbiter plus a behavioural EU.
module tb_exec_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    exec_arbiter_if bus ();

    exec_arbiter #(.PRIO_INIT(1'b0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural execution unit: class 0 add/sub, 1 logic/shift,
    // 2 signed compare, 3 unsigned compare; returns {y, flags}.
    function automatic logic [68:0] eu_calc(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input logic [7:0] op);
        logic [64:0] s;
        logic [63:0] y;
        logic lt, ltu, ov;
        s   = op[6] ? ({1'b0, a} + {1'b0, ~b} + 65'd1)
                    : ({1'b0, a} + {1'b0, b});
        lt  = $signed(a) < $signed(b);
        ltu = a < b;
        ov  = op[6] ? ((a[63] != b[63]) && (s[63] != a[63]))
                    : ((a[63] == b[63]) && (s[63] != a[63]));
        case (op[5:4])
            2'd0: y = s[63:0];
            2'd1: begin
                case (op[3:2])
                    2'd0: y = a & b;
                    2'd1: y = a | b;
                    2'd2: y = a ^ b;
                    default: begin
                        case (op[1:0])
                            2'd0: y = a << b[5:0];
                            2'd1: y = a >> b[5:0];
                            2'd2: y = $unsigned($signed(a) >>> b[5:0]);
                            default: y = a;
                        endcase
                    end
                endcase
            end
            2'd2: y = {63'd0, lt};
            default: y = {63'd0, ltu};
        endcase
        if (op[7]) y = {{32{y[31]}}, y[31:0]};
        return {y, (y == 64'd0), lt, ltu, s[64], ov};
    endfunction

    always_comb begin
        {bus.eu_y, bus.eu_zero, bus.eu_alt_b, bus.eu_alt_bu,
         bus.eu_cout, bus.eu_ovfl} = eu_calc(bus.eu_a, bus.eu_b,
            {bus.eu_ext_word, bus.eu_add_n_sub, bus.eu_func_class,
             bus.eu_logic_fn, bus.eu_shift_fn});
    end

    // Drive values for the next cycle.
    logic        d_v0, d_v1, d_rr0, d_rr1;
    logic [63:0] d_a0, d_b0, d_a1, d_b1;
    logic [7:0]  d_o0, d_o1;

    // Transaction-level reference state.
    logic        m_prio;
    logic        m_have;
    int          m_age;
    logic        m_owner;
    logic [63:0] m_a, m_b;
    logic [7:0]  m_op;
    logic [68:0] m_ref;
    logic [63:0] m_rsp_y;
    logic [4:0]  m_rsp_f;

    // Observations from the last step.
    int          cyc = 0;
    logic        last_acc, last_g, last_v0, last_v1;
    logic [63:0] last_y;
    logic [4:0]  last_f;
    int          acc_cyc[$];
    logic        acc_own[$];

    task automatic model_reset();
        m_prio  = 1'b0;
        m_have  = 1'b0;
        m_age   = 0;
        m_owner = 1'b0;
        m_a     = '0;
        m_b     = '0;
        m_op    = '0;
        m_ref   = '0;
        m_rsp_y = '0;
        m_rsp_f = '0;
    endtask

    task automatic idle_inputs();
        d_v0 = 0; d_v1 = 0; d_rr0 = 0; d_rr1 = 0;
        d_a0 = '0; d_b0 = '0; d_a1 = '0; d_b1 = '0;
        d_o0 = '0; d_o1 = '0;
    endtask

    task automatic step();
        logic e_r0, e_r1, g, take, acc;
        @(negedge clk);
        bus.req0_valid = d_v0;  bus.req1_valid = d_v1;
        bus.req0_a = d_a0;      bus.req0_b = d_b0;  bus.req0_op = d_o0;
        bus.req1_a = d_a1;      bus.req1_b = d_b1;  bus.req1_op = d_o1;
        bus.rsp0_ready = d_rr0; bus.rsp1_ready = d_rr1;
        #1;
        e_r0 = 0; e_r1 = 0; g = 0;
        if (!m_have && (d_v0 || d_v1)) begin
            g = (d_v0 && d_v1) ? m_prio : d_v1;
            e_r0 = ~g;
            e_r1 = g;
        end
        chk("req0_ready", bus.req0_ready, e_r0);
        chk("req1_ready", bus.req1_ready, e_r1);
        chk("rsp0_valid", bus.rsp0_valid, m_have && m_age >= 2 && !m_owner);
        chk("rsp1_valid", bus.rsp1_valid, m_have && m_age >= 2 && m_owner);
        chk("busy", bus.busy, m_have);
        chk("rsp_y", bus.rsp_y, m_rsp_y);
        chk("rsp_flags", bus.rsp_flags, m_rsp_f);
        chk("eu_a", bus.eu_a, m_a);
        chk("eu_b", bus.eu_b, m_b);
        chk("eu_op", {bus.eu_ext_word, bus.eu_add_n_sub, bus.eu_func_class,
                      bus.eu_logic_fn, bus.eu_shift_fn}, m_op);
        last_v0 = bus.rsp0_valid;
        last_v1 = bus.rsp1_valid;
        last_y  = bus.rsp_y;
        last_f  = bus.rsp_flags;
        @(posedge clk);
        cyc++;
        acc  = e_r0 || e_r1;
        take = m_have && m_age >= 2 && (m_owner ? d_rr1 : d_rr0);
        last_acc = acc;
        last_g   = g;
        if (acc) begin
            m_have  = 1;
            m_age   = 1;
            m_owner = g;
            m_a     = g ? d_a1 : d_a0;
            m_b     = g ? d_b1 : d_b0;
            m_op    = g ? d_o1 : d_o0;
            m_ref   = eu_calc(m_a, m_b, m_op);
            acc_cyc.push_back(cyc);
            acc_own.push_back(g);
        end else if (m_have) begin
            if (m_age == 1) begin
                m_age   = 2;
                m_rsp_y = m_ref[68:5];
                m_rsp_f = m_ref[4:0];
            end else if (take) begin
                m_have = 0;
                m_prio = ~m_owner;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        bus.req0_valid = 0; bus.req1_valid = 0;
        bus.rsp0_ready = 0; bus.rsp1_ready = 0;
        reset_n = 0;
        #1;
        model_reset();
        chk("rst_busy", bus.busy, 0);
        chk("rst_rsp_v", {bus.rsp1_valid, bus.rsp0_valid}, 0);
        chk("rst_rsp_y", bus.rsp_y, 0);
        chk("rst_flags", bus.rsp_flags, 0);
        chk("rst_eu_a", bus.eu_a, 0);
        chk("rst_eu_b", bus.eu_b, 0);
        @(negedge clk);
        reset_n = 1;
    endtask

    logic [63:0] pick64;
    task automatic rand64();
        case ($urandom_range(0, 4))
            0: pick64 = '0;
            1: pick64 = '1;
            2: pick64 = 64'h8000_0000_0000_0000;
            default: pick64 = {$urandom, $urandom};
        endcase
    endtask

    int n_acc0;

    initial begin
        idle_inputs();
        model_reset();
        bus.req0_valid = 0; bus.req1_valid = 0;
        bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
        bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
        bus.rsp0_ready = 0; bus.rsp1_ready = 0;
        do_reset();

        // Signed compare on req0.
        idle_inputs();
        d_v0 = 1; d_a0 = '1; d_b0 = 64'd1; d_o0 = 8'h60; d_rr0 = 1;
        step();
        chk("t1_acc", last_acc, 1);
        idle_inputs(); d_rr0 = 1;
        step();
        chk("t1_exec_v0", last_v0, 0);
        step();
        chk("t1_v0", last_v0, 1);
        chk("t1_v1", last_v1, 0);
        chk("t1_y", last_y, 64'd1);
        chk("t1_altb", last_f[3], 1);

        // Unsigned compare on req1.
        idle_inputs();
        d_v1 = 1; d_a1 = '1; d_b1 = 64'd1; d_o1 = 8'h70; d_rr1 = 1;
        step();
        idle_inputs(); d_rr1 = 1;
        step();
        step();
        chk("t2_v1", last_v1, 1);
        chk("t2_v0", last_v0, 0);
        chk("t2_y", last_y, 64'd0);
        chk("t2_altbu", last_f[2], 0);

        // Both valid continuously: alternating grants, 3-cycle spacing.
        do_reset();
        acc_cyc.delete(); acc_own.delete();
        idle_inputs();
        d_v0 = 1; d_v1 = 1; d_rr0 = 1; d_rr1 = 1;
        d_a0 = 64'd10; d_b0 = 64'd3; d_o0 = 8'h00;
        d_a1 = 64'd10; d_b1 = 64'd3; d_o1 = 8'h40;
        repeat (12) step();
        chk("t3_n", acc_own.size(), 4);
        for (int i = 0; i < 4 && i < acc_own.size(); i++) begin
            chk($sformatf("t3_own%0d", i), acc_own[i], i % 2);
            if (i > 0) chk($sformatf("t3_gap%0d", i),
                           acc_cyc[i] - acc_cyc[i-1], 3);
        end

        // Backpressure on rsp0 while req1 waits.
        idle_inputs();
        step();
        d_v0 = 1; d_a0 = 64'h1234; d_b0 = 64'h0F0F; d_o0 = 8'h14;
        step();
        chk("t4_acc0", last_acc, 1);
        idle_inputs();
        d_v1 = 1; d_a1 = 64'd7; d_b1 = 64'd9; d_o1 = 8'h00;
        step();
        repeat (5) begin
            step();
            chk("t4_y_hold", last_y, 64'h1234 | 64'h0F0F);
        end
        d_rr0 = 1;
        step();
        d_rr0 = 0;
        step();
        chk("t4_acc1", last_acc, 1);
        chk("t4_g1", last_g, 1);
        idle_inputs(); d_rr1 = 1;
        repeat (3) step();

        // Reset during EXEC drops the op.
        idle_inputs();
        d_v1 = 1; d_a1 = 64'd5; d_b1 = 64'd6; d_o1 = 8'h00;
        step();
        chk("t5_acc", last_acc, 1);
        do_reset();
        idle_inputs(); d_rr0 = 1; d_rr1 = 1;
        repeat (4) begin
            step();
            chk("t5_noresp", {last_v1, last_v0}, 0);
        end
        d_v0 = 1; d_v1 = 1;
        d_a0 = 64'd2; d_b0 = 64'd2; d_o0 = 8'h00;
        d_a1 = 64'd3; d_b1 = 64'd3; d_o1 = 8'h00;
        step();
        chk("t5_prio_init", last_g, 0);
        d_v0 = 0; d_v1 = 0;
        step();
        step();
        chk("t5_y", last_y, 64'd4);

        // Lone requester back-to-back.
        idle_inputs();
        acc_own.delete();
        d_v0 = 1; d_rr0 = 1; d_a0 = 64'd1; d_b0 = 64'd1; d_o0 = 8'h00;
        repeat (9) step();
        n_acc0 = 0;
        foreach (acc_own[i]) if (acc_own[i] == 1'b0) n_acc0++;
        chk("t6_served", n_acc0, 3);

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            d_v0 = ($urandom_range(0, 9) < 6);
            d_v1 = ($urandom_range(0, 9) < 6);
            rand64(); d_a0 = pick64;
            rand64(); d_b0 = pick64;
            rand64(); d_a1 = pick64;
            rand64(); d_b1 = pick64;
            d_o0 = 8'($urandom);
            d_o1 = 8'($urandom);
            d_rr0 = ($urandom_range(0, 3) != 0);
            d_rr1 = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/exec_arbiter.md
# exec_arbiter

Two-requester arbiter and sequencer for the shared 64-bit execution unit. Accepts operations from two independent requesters over valid/ready handshakes and grants round-robin. Registers each operation's operands and controls toward the execution unit, then captures its result and flags. Holds each result in a per-transaction response register until the owning requester accepts it. Sits between the issue stages and the single execution-unit instance.

## Interface

- PRIO_INIT, 0, requester holding priority after reset (0 or 1)

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  operation offered
- req0_ready / req1_ready  out  1  operation accepted this cycle when high with valid
- req0_a / req1_a  in  64  operand A
- req0_b / req1_b  in  64  operand B
- req0_op / req1_op  in  8  [1:0] ShiftFn, [3:2] LogicFn, [5:4] FuncClass, [6] AddnSub, [7] ExtWord
- rsp0_valid / rsp1_valid  out  1  result available for that requester
- rsp0_ready / rsp1_ready  in  1  requester takes result
- rsp_y  out  64  result value, shared by both response ports
- rsp_flags  out  5  {Zero, AltB, AltBu, Cout, Ovfl}, shared by both response ports
- busy  out  1  high whenever state is not IDLE
- eu_a, eu_b  out  64  operands to the execution unit
- eu_shift_fn, eu_logic_fn, eu_func_class  out  2 each  control to the execution unit
- eu_add_n_sub, eu_ext_word  out  1 each  control to the execution unit
- eu_y  in  64  execution unit result
- eu_zero, eu_alt_b, eu_alt_bu, eu_cout, eu_ovfl  in  1 each  execution unit flags

## Operation

- States: IDLE, EXEC, HOLD.
- Grant, evaluated combinationally in IDLE only:
  - Only one valid: grant that requester.
  - Both valid: grant the requester indicated by the priority pointer `prio`.
  - `req_ready[i] = (state==IDLE) && grant==i`. Ready depends on valid.
  - At most one ready is high in any cycle.
- IDLE:
  - Accept handshake fires: latch A, B and the op fields into the eu_* registers.
  - Record `owner = i` and go to EXEC.
  - With no valid, stay in IDLE; the eu_* outputs hold their last values.
- EXEC (exactly one cycle): the execution unit is combinational; at the cycle end, capture `eu_y` into `rsp_y` and the five flags into `rsp_flags`, then go to HOLD.
- HOLD:
  - `rsp_valid[owner]=1`; the other rsp_valid is 0.
  - `rsp_y` and `rsp_flags` are stable until the handshake.
  - When `rsp_ready[owner]` is high, go to IDLE and set `prio = ~owner`.
  - `rsp_ready` of the non-owner is ignored.
  - No request is accepted in a cycle where the state is HOLD.
- `prio` changes only on a response handshake. A requester that is served yields priority even if the other requester was idle.
- The op byte is passed through bit-exactly; no decoding or checking.
- Reset (asynchronous, any state) has these effects:
  - state=IDLE and `prio=PRIO_INIT`.
  - All eu_* outputs, `rsp_y` and `rsp_flags` are 0.
  - Both rsp_valid are 0 and busy=0.
  - An in-flight transaction is discarded with no response.

## Timing

- An accept at the rising edge ending cycle N puts EXEC in cycle N+1. rsp_valid is high from cycle N+2.
- Minimum spacing between accepts is 3 cycles, when the response is taken on its first valid cycle.
- Response backpressure extends HOLD indefinitely; the request side is stalled during it.
- The eu_* outputs are registers with no combinational path from req_* to eu_*.
- `rsp_y` and `rsp_flags` are registers.
- Requester stability: a requester with valid high and ready low must keep its A, B and op stable. The arbiter does not require this for correctness, since operands are latched only on accept.
- Simultaneous first requests after reset: `PRIO_INIT` wins.

## Test plan

- Reset, then req0 only: A=0xFFFF_FFFF_FFFF_FFFF, B=1, op=0x60 (signed compare, subtract). Required: req0_ready in the same cycle; rsp0_valid exactly 2 cycles after accept; rsp_y=1; AltB=1; rsp1_valid stays 0.
- Same operands on req1 with op=0x70 (unsigned compare). Required: rsp_y=0, AltBu=0, delivered only on rsp1_valid.
- Both valid continuously, PRIO_INIT=0, rsp_ready tied high. Required: grants alternate 0,1,0,1 across 4 transactions, accepts are 3 cycles apart, and each result returns to the correct port.
- rsp0_ready held low for 5 cycles while req1 is valid. Required: rsp_y and rsp_flags stable, req1_ready low throughout, and req1 accepted the cycle after the rsp0 handshake.
- reset_n asserted during EXEC, then released. Required: all outputs read 0 immediately and no rsp_valid ever appears for the dropped op. The next request completes normally with `prio=PRIO_INIT`.
- req0 alone, 3 back-to-back transactions. Required: all served despite `prio` flipping to 1 after each, since lone-requester grant ignores `prio`.
